// File: rtl/mag_seq_ctrl.sv
// Vector-magnitude sequencer: accumulates sum((e*e)>>8) over NCHUNK 4-element chunks,
// runs a 16-cycle bit-serial integer square root, then holds the result for the consumer.
module mag_seq_ctrl #(
  parameter int unsigned NCHUNK = 4,
  parameter int unsigned CNT_W  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_mag,
  output logic        out_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {StAccum, StSqrt, StDone} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      rem_q, rem_d;
  logic [15:0]      root_q, root_d;
  logic [3:0]       iter_q, iter_d;

  logic [33:0]        acc_sum;
  logic signed [15:0] elem;
  logic signed [31:0] sq;

  // Sum of the four truncated squares plus the running accumulator, with headroom for overflow.
  always_comb begin
    acc_sum = {2'b00, acc_q};
    elem    = '0;
    sq      = '0;
    for (int i = 0; i < 4; i++) begin
      elem    = in_data[63-16*i -: 16];
      sq      = 32'(elem) * 32'(elem);
      acc_sum = acc_sum + 34'(unsigned'(sq) >> 8);
    end
  end

  logic [17:0] rem_t;
  logic [17:0] trial;
  logic        ge;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    root_d  = root_q;
    iter_d  = iter_q;
    // Restoring bit-pair step: bring down the top two acc bits, try subtracting 4*root+1.
    rem_t   = {rem_q, acc_q[31:30]};
    trial   = {root_q, 2'b01};
    ge      = rem_t >= trial;

    unique case (state_q)
      StAccum: begin
        if (in_valid) begin
          if (acc_sum[33:32] != 2'b00) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = acc_sum[31:0];
          end
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            state_d = StSqrt;
            rem_d   = '0;
            root_d  = '0;
            iter_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StSqrt: begin
        // Remainder never exceeds 16 bits before the final step; the last remainder is discarded.
        rem_d  = 16'(ge ? rem_t - trial : rem_t);
        root_d = {root_q[14:0], ge};
        acc_d  = acc_q << 2;
        iter_d = iter_q + 1'b1;
        if (iter_q == 4'd15) state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StAccum;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
      root_q  <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      iter_q  <= iter_d;
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StDone);
  assign out_mag   = root_q;
  assign out_ovf   = ovf_q;
  assign busy      = (state_q != StAccum) || (cnt_q != '0);

endmodule

// File: tb/tb_mag_seq_ctrl.sv
// Randomized bench for mag_seq_ctrl: three instances (NCHUNK 4, 1024, 1) sharing one stimulus
// bus, checked against an arithmetic reference of the magnitude and the handshake timing.
module tb_mag_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [63:0] in_data;
  int          sel;

  logic [2:0]       ir, ov, oo, bz;
  logic [2:0][15:0] om;
  logic             in_ready, out_valid, out_ovf, busy;
  logic [15:0]      out_mag;

  assign in_ready  = ir[sel];
  assign out_valid = ov[sel];
  assign out_ovf   = oo[sel];
  assign busy      = bz[sel];
  assign out_mag   = om[sel];

  mag_seq_ctrl #(.NCHUNK(4), .CNT_W(10)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready && sel == 0),
    .out_mag(om[0]), .out_ovf(oo[0]), .busy(bz[0])
  );

  mag_seq_ctrl #(.NCHUNK(1024), .CNT_W(10)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready && sel == 1),
    .out_mag(om[1]), .out_ovf(oo[1]), .busy(bz[1])
  );

  mag_seq_ctrl #(.NCHUNK(1), .CNT_W(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready && sel == 2),
    .out_mag(om[2]), .out_ovf(oo[2]), .busy(bz[2])
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  logic [63:0] vec[$];

  // Reference: sum of floor(e^2/256) over every element, clamped to 32 bits.
  task automatic model(output longint acc, output longint ovf);
    longint sum = 0;
    longint v;
    logic [63:0] ch;
    logic [15:0] e;
    foreach (vec[c]) begin
      ch = vec[c];
      for (int i = 0; i < 4; i++) begin
        e   = ch[63-16*i -: 16];
        v   = longint'($signed(e));
        sum = sum + (v * v) / 256;
      end
    end
    ovf = (sum > 64'hFFFF_FFFF) ? 1 : 0;
    acc = (sum > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : sum;
  endtask

  function automatic longint isqrt(input longint v);
    longint r = longint'($sqrt(real'(v)));
    while (r * r > v) r--;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic logic [15:0] rand_elem();
    int unsigned r = $urandom_range(9, 0);
    if (r == 0) return 16'h8000;
    if (r == 1) return 16'h7FFF;
    if (r < 5)  return 16'($urandom);
    return 16'($urandom_range(2047, 0) - 1024);
  endfunction

  task automatic fill(input int n, input logic [15:0] e);
    vec.delete();
    for (int c = 0; c < n; c++) vec.push_back({e, e, e, e});
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_mag"}, out_mag, 0);
    chk({tag, "_out_ovf"}, out_ovf, 0);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives the first n chunks of vec with gmin..gmax idle cycles before each beat.
  task automatic send_beats(input int n, input int gmin, input int gmax);
    int k;
    for (int c = 0; c < n; c++) begin
      repeat ($urandom_range(gmax, gmin)) begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        @(negedge clk);
      end
      k = 0;
      while (!in_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("in_ready_accum", in_ready, 1);
      if (c > 0) chk("busy_accum", busy, 1);
      in_valid = 1'b1;
      in_data  = vec[c];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Counts cycles from the last beat to out_valid while offering junk chunks that must be ignored.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("in_ready_sqrt", in_ready, 0);
      in_valid = 1'($urandom);
      in_data  = {$urandom, $urandom};
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vector(input int gmin, input int gmax, input int hmin, input int hmax);
    longint acc, ovf, mag;
    int lat;
    model(acc, ovf);
    mag = isqrt(acc);
    send_beats(vec.size(), gmin, gmax);
    wait_out(lat);
    chk("latency", lat, 16);
    chk("busy_done", busy, 1);
    repeat ($urandom_range(hmax, hmin)) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_mag", out_mag, mag);
      chk("hold_in_ready", in_ready, 0);
      in_valid = 1'($urandom);
      in_data  = {$urandom, $urandom};
      @(negedge clk);
    end
    chk("out_mag", out_mag, mag);
    chk("out_ovf", out_ovf, ovf);
    chk("out_valid", out_valid, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_busy", busy, 0);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    sel       = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // Unit elements: acc 4096, magnitude 64.
    fill(4, 16'h0100);
    run_vector(0, 0, 0, 0);

    // 3.0 and 4.0 in one chunk, then the negated 3.0.
    vec.delete();
    vec.push_back({16'h0300, 16'h0400, 16'h0000, 16'h0000});
    for (int c = 0; c < 3; c++) vec.push_back(64'h0);
    run_vector(0, 0, 0, 1);
    vec[0] = {16'hFD00, 16'h0400, 16'h0000, 16'h0000};
    run_vector(0, 0, 0, 1);

    // Two idle cycles between beats and a 10-cycle stall at the output.
    fill(4, 16'h0100);
    run_vector(2, 2, 10, 10);

    fill(4, 16'h0000);
    run_vector(0, 1, 0, 2);

    // Reset in the 8th square-root cycle, then a clean vector.
    fill(4, 16'h0100);
    send_beats(4, 0, 0);
    repeat (7) @(negedge clk);
    do_reset();
    check_reset_state("rst_sqrt");
    run_vector(0, 0, 0, 0);

    // Reset mid-accumulation must drop the partial sum.
    fill(4, 16'h7FFF);
    send_beats(2, 0, 0);
    do_reset();
    check_reset_state("rst_accum");
    vec.delete();
    vec.push_back({16'h0300, 16'h0400, 16'h0000, 16'h0000});
    for (int c = 0; c < 3; c++) vec.push_back(64'h0);
    run_vector(0, 1, 0, 0);

    // Reset while the result waits in DONE.
    fill(4, 16'h0100);
    send_beats(4, 0, 0);
    wait_out(lat);
    chk("rst_done_latency", lat, 16);
    repeat (3) @(negedge clk);
    do_reset();
    check_reset_state("rst_done");
    fill(4, 16'h0200);
    run_vector(0, 0, 0, 0);

    // Long vector of -128.0 saturates, then an all-zero vector clears the flag.
    sel = 1;
    fill(1024, 16'h8000);
    run_vector(0, 0, 0, 2);
    fill(1024, 16'h0000);
    run_vector(0, 0, 0, 2);

    // Single-chunk vectors go straight to the root.
    sel = 2;
    for (int v = 0; v < 20; v++) begin
      vec.delete();
      vec.push_back({rand_elem(), rand_elem(), rand_elem(), rand_elem()});
      run_vector(0, 2, 0, 3);
    end

    // Random vectors with random gaps and consumer stalls.
    sel = 0;
    for (int v = 0; v < 1000; v++) begin
      vec.delete();
      for (int c = 0; c < 4; c++) vec.push_back({rand_elem(), rand_elem(), rand_elem(), rand_elem()});
      run_vector(0, 2, 0, 3);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
